alu_seq: RTL and testbench

//  Registered, parametrised successor of the processor's combinational ALU.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and result bus for alu_seq: operation request in, registered result and flags out.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             C;
    logic             L;
    logic             F;
    logic             Z;
    logic             N;

    modport master (
        output in_valid, aluControl, a, b,
        input  in_ready, out_valid, result, C, L, F, Z, N
    );

    modport slave (
        input  in_valid, aluControl, a, b,
        output in_ready, out_valid, result, C, L, F, Z, N
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flag register, shifter and optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (opcode 1010); otherwise 1010 is undefined.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_MOVI = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SHF  = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam int         CNT_W   = $clog2(WIDTH) + 1;
`endif

    logic [WIDTH-1:0]        result_q, result_d;
    logic                    c_q, c_d, l_q, l_d, f_q, f_d, z_q, z_d, n_q, n_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]          sum_w, diff_w;
    logic [SHW-1:0]          sh_amt;
    logic [WIDTH-1:0]        sh_res;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {IDLE, MUL_BUSY} state_e;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_next;
    logic [WIDTH-1:0]     mplier_q, mplier_d;

    assign bus.in_ready = (state_q == IDLE);
    assign acc_next     = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign bus.in_ready = 1'b1;
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign a_s    = signed'(bus.a);
    assign b_s    = signed'(bus.b);
    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign sh_amt = bus.b[SHW-1:0];

    // b's MSB picks direction; amounts past the word width flush to zero
    always_comb begin
        sh_res = '0;
        if (32'(sh_amt) < WIDTH) begin
            sh_res = bus.b[WIDTH-1] ? (bus.a >> sh_amt) : (bus.a << sh_amt);
        end
    end

    always_comb begin
        result_d    = result_q;
        c_d         = c_q;
        l_d         = l_q;
        f_d         = f_q;
        z_d         = z_q;
        n_d         = n_q;
        out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            case (bus.aluControl)
                OP_NOP: ;
                OP_SUB: begin
                    result_d = diff_w[WIDTH-1:0];
                    c_d      = diff_w[WIDTH];
                    f_d      = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
                    z_d      = (diff_w[WIDTH-1:0] == '0);
                    n_d      = diff_w[WIDTH-1];
                    l_d      = 1'b0;
                end
                OP_CMP: begin
                    l_d = (bus.a < bus.b);
                    n_d = (a_s < b_s);
                    z_d = (bus.a == bus.b);
                    c_d = 1'b0;
                    f_d = 1'b0;
                end
                OP_AND:  result_d = bus.a & bus.b;
                OP_OR:   result_d = bus.a | bus.b;
                OP_XOR:  result_d = bus.a ^ bus.b;
                OP_MOV:  result_d = bus.a;
                OP_MOVI: result_d = bus.b;
                OP_ADD: begin
                    result_d = sum_w[WIDTH-1:0];
                    c_d      = sum_w[WIDTH];
                    f_d      = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                               (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
                    z_d      = (sum_w[WIDTH-1:0] == '0);
                    n_d      = sum_w[WIDTH-1];
                    l_d      = 1'b0;
                end
                OP_SHF: result_d = sh_res;
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    out_valid_d = 1'b0;
                    state_d     = MUL_BUSY;
                    cnt_d       = '0;
                    acc_d       = '0;
                    mcand_d     = {{WIDTH{1'b0}}, bus.a};
                    mplier_d    = bus.b;
                end
`endif
                default: result_d = '0;
            endcase
`ifdef ALU_SEQ_MUL_EN
        end else if (state_q == MUL_BUSY) begin
            // one partial product per clock; the last one lands directly in result
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                result_d    = acc_next[WIDTH-1:0];
                c_d         = |acc_next[2*WIDTH-1:WIDTH];
                f_d         = |acc_next[2*WIDTH-1:WIDTH];
                z_d         = (acc_next[WIDTH-1:0] == '0);
                n_d         = acc_next[WIDTH-1];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            c_q         <= 1'b0;
            l_q         <= 1'b0;
            f_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= IDLE;
            cnt_q       <= '0;
`endif
        end else begin
            result_q    <= result_d;
            c_q         <= c_d;
            l_q         <= l_d;
            f_q         <= f_d;
            z_q         <= z_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.C         = c_q;
    assign bus.L         = l_q;
    assign bus.F         = f_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed scenarios plus random ops against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] m_res;
    logic        m_c, m_l, m_f, m_z, m_n;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W), .SHW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    function automatic logic [21:0] obs();
        return {bus.out_valid, bus.result, bus.C, bus.L, bus.F, bus.Z, bus.N};
    endfunction

    function automatic logic [21:0] expv();
        return {1'b1, m_res, m_c, m_l, m_f, m_z, m_n};
    endfunction

    task automatic model_reset();
        m_res = '0; m_c = 0; m_l = 0; m_f = 0; m_z = 0; m_n = 0;
    endtask

    // Reference: plain integer arithmetic on the opcode rules
    task automatic model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua, ub, sa, sb, r, p;
        int amt;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        case (op)
            4'd0: ;
            4'd1: begin
                r = ua - ub; m_res = 16'(r); m_c = (ua < ub);
                m_f = ((sa - sb) < -32768) || ((sa - sb) > 32767);
                m_z = (m_res == 0); m_n = m_res[15]; m_l = 0;
            end
            4'd2: begin
                m_l = (ua < ub); m_n = (sa < sb); m_z = (ua == ub); m_c = 0; m_f = 0;
            end
            4'd3: m_res = a & b;
            4'd4: m_res = a | b;
            4'd5: m_res = a ^ b;
            4'd6: m_res = a;
            4'd7: m_res = b;
            4'd8: begin
                r = ua + ub; m_res = 16'(r); m_c = (r > 65535);
                m_f = ((sa + sb) < -32768) || ((sa + sb) > 32767);
                m_z = (m_res == 0); m_n = m_res[15]; m_l = 0;
            end
            4'd9: begin
                amt = int'(b[3:0]);
                if (amt >= 16) m_res = 0;
                else if (b[15]) m_res = 16'(ua / (64'd1 << amt));
                else m_res = 16'((ua * (64'd1 << amt)) % 65536);
            end
            4'd10: begin
                if (MUL_EN) begin
                    p = ua * ub; m_res = 16'(p % 65536);
                    m_c = (p >= 65536); m_f = m_c; m_z = (m_res == 0); m_n = m_res[15];
                end else m_res = 0;
            end
            default: m_res = 0;
        endcase
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.aluControl = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_op(op, a, b);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.aluControl = 4'd0; bus.a = '0; bus.b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 22'h0) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs(), 22'h0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith_flags();
        issue(4'b1000, 16'hFFFF, 16'h0001);
        checks++;
        if (obs() !== {1'b1, 16'h0000, 5'b10010}) begin
            failures++; $display("FAIL add_carry got=%h exp=%h", obs(), {1'b1, 16'h0000, 5'b10010});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL out_valid_pulse got=%b exp=0", bus.out_valid);
        end
        issue(4'b0001, 16'h8000, 16'h0001);
        checks++;
        if (obs() !== {1'b1, 16'h7FFF, 5'b00100}) begin
            failures++; $display("FAIL sub_ovf got=%h exp=%h", obs(), {1'b1, 16'h7FFF, 5'b00100});
        end
        issue(4'b0011, 16'hF0F0, 16'h0FF0);
        checks++;
        if (obs() !== {1'b1, 16'h00F0, 5'b00100}) begin
            failures++; $display("FAIL and_keeps_flags got=%h exp=%h", obs(), {1'b1, 16'h00F0, 5'b00100});
        end
        issue(4'b0010, 16'h0001, 16'hFFFF);
        checks++;
        if (obs() !== {1'b1, 16'h00F0, 5'b01000}) begin
            failures++; $display("FAIL cmp got=%h exp=%h", obs(), {1'b1, 16'h00F0, 5'b01000});
        end
        issue(4'b0000, 16'h1234, 16'h5678);
        checks++;
        if (obs() !== {1'b1, 16'h00F0, 5'b01000}) begin
            failures++; $display("FAIL nop got=%h exp=%h", obs(), {1'b1, 16'h00F0, 5'b01000});
        end
    endtask

    task automatic test_shift();
        issue(4'b1001, 16'h0081, 16'h0004);
        checks++;
        if (obs() !== {1'b1, 16'h0810, 5'b01000}) begin
            failures++; $display("FAIL shl4 got=%h exp=%h", obs(), {1'b1, 16'h0810, 5'b01000});
        end
        issue(4'b1001, 16'h0081, 16'h8004);
        checks++;
        if (obs() !== {1'b1, 16'h0008, 5'b01000}) begin
            failures++; $display("FAIL shr4 got=%h exp=%h", obs(), {1'b1, 16'h0008, 5'b01000});
        end
        issue(4'b1001, 16'h0001, 16'h000F);
        checks++;
        if (obs() !== {1'b1, 16'h8000, 5'b01000}) begin
            failures++; $display("FAIL shl15 got=%h exp=%h", obs(), {1'b1, 16'h8000, 5'b01000});
        end
        issue(4'b1111, 16'h1111, 16'h2222);
        checks++;
        if (obs() !== {1'b1, 16'h0000, 5'b01000}) begin
            failures++; $display("FAIL undef_op got=%h exp=%h", obs(), {1'b1, 16'h0000, 5'b01000});
        end
    endtask

    task automatic test_mul();
        int n;
        int busy_low;
        issue(4'b0111, 16'h0000, 16'h4321);
        issue(4'b1010, 16'd300, 16'd300);
        busy_low = 0;
        n = 0;
        // hammer the inputs while busy; these must be dropped
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready === 1'b0) busy_low++;
            bus.in_valid = 1'b1; bus.aluControl = 4'b0111; bus.a = 16'h1111; bus.b = 16'hABCD;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (n !== (MUL_EN ? 16 : 0)) begin
            failures++; $display("FAIL mul_latency got=%0d exp=%0d", n, MUL_EN ? 16 : 0);
        end
        if (MUL_EN) begin
            checks++;
            if (busy_low !== 16) begin
                failures++; $display("FAIL mul_ready_low got=%0d exp=16", busy_low);
            end
        end
        checks++;
        if (obs() !== (MUL_EN ? {1'b1, 16'h5F90, 5'b11100} : {1'b1, 16'h0000, 5'b01000})) begin
            failures++;
            $display("FAIL mul_300x300 got=%h exp=%h", obs(),
                     MUL_EN ? {1'b1, 16'h5F90, 5'b11100} : {1'b1, 16'h0000, 5'b01000});
        end
    endtask

    task automatic test_reset_midrun();
        int pulses;
        issue(4'b1000, 16'h7FFF, 16'h0001);
        issue(4'b1010, 16'd300, 16'd300);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({obs(), bus.in_ready} !== {22'h0, 1'b1}) begin
            failures++; $display("FAIL reset_midrun got=%h exp=%h", {obs(), bus.in_ready}, {22'h0, 1'b1});
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++; $display("FAIL reset_abort_pulses got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_random_back_to_back();
        int n;
        logic [3:0] op;
        logic [15:0] a, b;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            issue(op, a, b);
            wait_out(n);
            checks++;
            if (n !== ((MUL_EN && op == 4'd10) ? 16 : 0) || obs() !== expv()) begin
                failures++;
                $display("FAIL rand_op%0h a=%h b=%h got=%h lat=%0d exp=%h", op, a, b, obs(), n, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith_flags();
        test_shift();
        test_mul();
        test_reset_midrun();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
